uart_file_xfer: RTL

Parametrised host-file transfer engine sitting between the rs232 byte link and a byte-wide on-chip buffer RAM. It replaces the inline IO / SEND_HEAD / SEND_FILE_INDEX / READ_GET_BYTE / WRITE_SEND_BYTE sequence in the top-level controller with a reusable block. A command gives direction, file index, base address and length. The block sends the header and the index, then streams bytes from rx into RAM, or from RAM to tx, and reports done or error.

---
 rtl/uart_file_xfer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_file_xfer.sv
// uart_file_xfer: host-file transfer engine (header, index, then rx->RAM or RAM->tx); optional macro CHECKSUM_EN adds a modulo-256 data checksum byte
module uart_file_xfer #(
  parameter int ADDR_W = 12,
  parameter int LEN_W = 12,
  parameter int IDX_BYTES = 2,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0] HDR_RD = 8'd82,
  parameter logic [7:0] HDR_WR = 8'd87
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_start,
  input  logic cmd_write,
  input  logic [IDX_BYTES*8-1:0] cmd_index,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0] cmd_len,
  output logic busy,
  output logic done,
  output logic err,
  output logic [7:0] tx_data,
  output logic tx_en,
  input  logic tx_busy,
  input  logic [7:0] rx_data,
  input  logic rx_rdy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic mem_we,
  input  logic [7:0] mem_rdata
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [3:0] {
    IDLE, HDR, IDX, RD, RD_CK, WR_FETCH, WR_LAT, WR_SEND, WR_CK, TXGAP, TXWAIT, DONE
  } state_t;
`ifdef CHECKSUM_EN
  localparam state_t RD_END = RD_CK;
  localparam state_t WR_END = WR_CK;
  logic [7:0] sum;
`else
  localparam state_t RD_END = DONE;
  localparam state_t WR_END = DONE;
`endif
  state_t state, nxt;
  logic wr;
  logic [IDX_BYTES*8-1:0] idx_sr;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0] len, cnt, cnt_inc;
  logic [TW-1:0] tmo;
  logic tmo_hit;
  assign cnt_inc = cnt + LEN_W'(1);
  assign tmo_hit = tmo == TW'(TIMEOUT_CYC - 1);
  // Transfer sequencer; every transmitted byte goes out via TXGAP/TXWAIT and resumes at nxt
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      nxt <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      tx_en <= 1'b0;
      tx_data <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      wr <= 1'b0;
      idx_sr <= '0;
      base <= '0;
      len <= '0;
      cnt <= '0;
      tmo <= '0;
`ifdef CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      done <= 1'b0;
      tx_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: if (cmd_start) begin
          wr <= cmd_write;
          idx_sr <= cmd_index;
          base <= cmd_base;
          len <= cmd_len;
          cnt <= '0;
          tmo <= '0;
          err <= 1'b0;
          busy <= 1'b1;
`ifdef CHECKSUM_EN
          sum <= '0;
`endif
          state <= HDR;
        end
        HDR: if (!tx_busy) begin
          tx_data <= wr ? HDR_WR : HDR_RD;
          tx_en <= 1'b1;
          nxt <= IDX;
          state <= TXGAP;
        end
        IDX: if (!tx_busy) begin
          tx_data <= idx_sr[7:0];
          tx_en <= 1'b1;
          idx_sr <= idx_sr >> 8;
          cnt <= (cnt_inc == LEN_W'(IDX_BYTES)) ? '0 : cnt_inc;
          nxt <= (cnt_inc != LEN_W'(IDX_BYTES)) ? IDX : (len == '0) ? DONE : wr ? WR_FETCH : RD;
          state <= TXGAP;
        end
        RD: if (rx_rdy) begin
          mem_addr <= base + ADDR_W'(cnt);
          mem_wdata <= rx_data;
          mem_we <= 1'b1;
          cnt <= cnt_inc;
          tmo <= '0;
`ifdef CHECKSUM_EN
          sum <= sum + rx_data;
`endif
          state <= (cnt_inc == len) ? RD_END : RD;
        end else if (tmo_hit) begin
          err <= 1'b1;
          state <= DONE;
        end else begin
          tmo <= tmo + TW'(1);
        end
`ifdef CHECKSUM_EN
        RD_CK: if (rx_rdy) begin
          err <= rx_data != sum;
          state <= DONE;
        end else if (tmo_hit) begin
          err <= 1'b1;
          state <= DONE;
        end else begin
          tmo <= tmo + TW'(1);
        end
        WR_CK: if (!tx_busy) begin
          tx_data <= sum;
          tx_en <= 1'b1;
          nxt <= DONE;
          state <= TXGAP;
        end
`endif
        WR_FETCH: begin
          mem_addr <= base + ADDR_W'(cnt);
          state <= WR_LAT;
        end
        WR_LAT: state <= WR_SEND;
        WR_SEND: if (!tx_busy) begin
          tx_data <= mem_rdata;
          tx_en <= 1'b1;
          cnt <= cnt_inc;
`ifdef CHECKSUM_EN
          sum <= sum + mem_rdata;
`endif
          nxt <= (cnt_inc < len) ? WR_FETCH : WR_END;
          state <= TXGAP;
        end
        TXGAP: state <= TXWAIT;
        TXWAIT: if (!tx_busy) state <= nxt;
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
